// File: rtl/mfc_pkg.sv
// Shared types for the MFC operand generator: relation codes, FSM states
// and the default operand width.
package mfc_pkg;

    localparam int MFC_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_EQ   = 2'd0,
        OP_AE   = 2'd1,
        OP_DIFF = 2'd2,
        OP_LT   = 2'd3
    } mfc_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A target bit index at or beyond the operand width cannot be flipped.
    function automatic logic d_out_of_range(input int unsigned d, input int unsigned w);
        return d >= w;
    endfunction

endpackage

// File: rtl/mfc_bit_cell.sv
// One bit of the serial operand builder. flag carries the "already seen a
// one" state for negation and the borrow for decrement.
module mfc_bit_cell
    import mfc_pkg::*;
(
    input  logic    a_i,
    input  mfc_op_e op,
    input  logic    hit,
    input  logic    flag_in,
    output logic    b_i,
    output logic    flag_out
);

    // Per-relation bit rule; flag passes through unchanged where unused.
    always_comb begin
        b_i      = a_i;
        flag_out = flag_in;
        case (op)
            OP_EQ:   b_i = a_i;
            OP_AE: begin
                b_i      = flag_in ? ~a_i : a_i;
                flag_out = flag_in | a_i;
            end
            OP_DIFF: b_i = a_i ^ hit;
            OP_LT: begin
                b_i      = a_i ^ flag_in;
                flag_out = flag_in & ~a_i;
            end
            default: b_i = a_i;
        endcase
    end

endmodule

// File: rtl/mfc_operand_gen.sv
// Builds an operand B, LSB first at one bit per clock, such that the
// multifunction comparator reports the requested relation against A.
module mfc_operand_gen
    import mfc_pkg::*;
#(
    parameter int WIDTH = MFC_WIDTH,
    parameter int D_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [1:0]       req_op,
    input  logic [D_W-1:0]   req_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_b,
    output logic             rsp_err,
    output logic             busy
);

    state_e           state, state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] sr;
    mfc_op_e          op_q;
    logic [D_W-1:0]   d_q;
    logic [D_W-1:0]   cnt;
    logic             flag_q;
    logic             err_q;

    logic a_i, b_i, flag_nxt, hit, last;

    assign a_i  = a_q[cnt];
    assign hit  = (cnt == d_q);
    assign last = (cnt == D_W'(WIDTH - 1));

    mfc_bit_cell u_cell (
        .a_i      (a_i),
        .op       (op_q),
        .hit      (hit),
        .flag_in  (flag_q),
        .b_i      (b_i),
        .flag_out (flag_nxt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept, run WIDTH bits, hold the result until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request, then shift result bits in from the MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            sr     <= '0;
            op_q   <= OP_EQ;
            d_q    <= '0;
            cnt    <= '0;
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_q    <= req_a;
                    op_q   <= mfc_op_e'(req_op);
                    d_q    <= req_d;
                    cnt    <= '0;
                    // Decrement starts with a borrow pending; everything else clear.
                    flag_q <= (mfc_op_e'(req_op) == OP_LT);
                    err_q  <= (mfc_op_e'(req_op) == OP_DIFF) &&
                              d_out_of_range(32'(req_d), WIDTH);
                end
                RUN: begin
                    cnt    <= cnt + 1'b1;
                    flag_q <= flag_nxt;
                    sr     <= {b_i, sr[WIDTH-1:1]};
                    // Borrow reaching a set sign bit means A is the most
                    // negative value: nothing smaller exists, return A.
                    if (last && op_q == OP_LT && flag_q && a_i) begin
                        err_q <= 1'b1;
                        sr    <= a_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_b     = sr;
    assign rsp_err   = err_q;

endmodule
